// File: rtl/comparator_1bit_data_ternary.sv
// Registered 1-bit magnitude comparator with one-hot GT/EQ/LT flags and saturating outcome counters.
// Latency: one clock from sampled A/B to flags. Backpressure: none; the flags hold while en is low.
module comparator_1bit_data_ternary #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             en,
  input  logic             clr,
  output logic             GT,
  output logic             EQ,
  output logic             LT,
  output logic             valid,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_gt_n;
  logic             w_eq_n;
  logic             w_lt_n;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;
  logic             r_valid;
  logic [CNT_W-1:0] r_gt_cnt;
  logic [CNT_W-1:0] r_eq_cnt;
  logic [CNT_W-1:0] r_lt_cnt;

  assign w_gt_n = A & ~B;
  assign w_eq_n = ~(A ^ B);
  assign w_lt_n = ~A & B;

  // The flags hold their last result while en is low. Only valid pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gt    <= 1'b0;
      r_eq    <= 1'b0;
      r_lt    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= en;
      if (en) begin
        r_gt <= w_gt_n;
        r_eq <= w_eq_n;
        r_lt <= w_lt_n;
      end
    end
  end

  // clr wins over a same-edge increment, so that compare is dropped from the stats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gt_cnt <= '0;
      r_eq_cnt <= '0;
      r_lt_cnt <= '0;
    end else if (clr) begin
      r_gt_cnt <= '0;
      r_eq_cnt <= '0;
      r_lt_cnt <= '0;
    end else if (en) begin
      if (w_gt_n && (r_gt_cnt != CNT_MAX)) r_gt_cnt <= r_gt_cnt + 1'b1;
      if (w_eq_n && (r_eq_cnt != CNT_MAX)) r_eq_cnt <= r_eq_cnt + 1'b1;
      if (w_lt_n && (r_lt_cnt != CNT_MAX)) r_lt_cnt <= r_lt_cnt + 1'b1;
    end
  end

  assign GT     = r_gt;
  assign EQ     = r_eq;
  assign LT     = r_lt;
  assign valid  = r_valid;
  assign gt_cnt = r_gt_cnt;
  assign eq_cnt = r_eq_cnt;
  assign lt_cnt = r_lt_cnt;

endmodule

// File: tb/tb_comparator_1bit_data_ternary.sv
// Directed and seeded-random checks of comparator_1bit_data_ternary.
// Uses an 8-bit counter instance and a 2-bit counter instance that share the same stimulus.
module tb_comparator_1bit_data_ternary;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       en;
  logic       clr;
  logic       gt;
  logic       eq;
  logic       lt;
  logic       vld;
  logic [7:0] gt_cnt;
  logic [7:0] eq_cnt;
  logic [7:0] lt_cnt;
  logic       s_gt;
  logic       s_eq;
  logic       s_lt;
  logic       s_vld;
  logic [1:0] s_gt_cnt;
  logic [1:0] s_eq_cnt;
  logic [1:0] s_lt_cnt;

  int checks = 0;
  int errors = 0;

  comparator_1bit_data_ternary #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .en(en), .clr(clr),
    .GT(gt), .EQ(eq), .LT(lt), .valid(vld),
    .gt_cnt(gt_cnt), .eq_cnt(eq_cnt), .lt_cnt(lt_cnt)
  );

  comparator_1bit_data_ternary #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .A(a), .B(b), .en(en), .clr(clr),
    .GT(s_gt), .EQ(s_eq), .LT(s_lt), .valid(s_vld),
    .gt_cnt(s_gt_cnt), .eq_cnt(s_eq_cnt), .lt_cnt(s_lt_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a = 1'b0; b = 1'b0; en = 1'b0; clr = 1'b0;
    #23;
    checks++;
    if ({gt, eq, lt, vld} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {gt, eq, lt, vld});
    end
    checks++;
    if ({gt_cnt, eq_cnt, lt_cnt} !== 24'h0) begin
      errors++; $display("FAIL reset_cnt got %h want 000000", {gt_cnt, eq_cnt, lt_cnt});
    end
    checks++;
    if ({s_gt, s_eq, s_lt, s_vld, s_gt_cnt, s_eq_cnt, s_lt_cnt} !== 10'h0) begin
      errors++; $display("FAIL reset_small got %h want 000", {s_gt, s_eq, s_lt, s_vld, s_gt_cnt, s_eq_cnt, s_lt_cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_truth_table();
    logic [1:0] ab  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0] exp [4] = '{4'b0101, 4'b0011, 4'b1001, 4'b0101};
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {a, b} = ab[i];
      edge_step();
      checks++;
      if ({gt, eq, lt, vld} !== exp[i]) begin
        errors++; $display("FAIL truth_%0d got %b want %b", i, {gt, eq, lt, vld}, exp[i]);
      end
    end
    checks++;
    if ({gt_cnt, eq_cnt, lt_cnt} !== {8'd1, 8'd2, 8'd1}) begin
      errors++; $display("FAIL truth_cnt got %h want 010201", {gt_cnt, eq_cnt, lt_cnt});
    end
  endtask

  task automatic test_enable_hold();
    en = 1'b1; a = 1'b1; b = 1'b0;
    edge_step();
    checks++;
    if ({gt, eq, lt, vld} !== 4'b1001) begin
      errors++; $display("FAIL hold_setup got %b want 1001", {gt, eq, lt, vld});
    end
    en = 1'b0; a = 1'b0; b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      edge_step();
      checks++;
      if ({gt, eq, lt, vld, lt_cnt} !== {4'b1000, 8'd1}) begin
        errors++; $display("FAIL hold_%0d got %b/%0d want 1000/1", i, {gt, eq, lt, vld}, lt_cnt);
      end
    end
    checks++;
    if (gt_cnt !== 8'd2) begin
      errors++; $display("FAIL hold_gt_cnt got %0d want 2", gt_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_s [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    en = 1'b0; clr = 1'b1;
    edge_step();
    clr = 1'b0; en = 1'b1; a = 1'b1; b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edge_step();
      checks++;
      if (s_eq_cnt !== exp_s[i]) begin
        errors++; $display("FAIL sat_small_%0d got %0d want %0d", i, s_eq_cnt, exp_s[i]);
      end
      checks++;
      if (eq_cnt !== 8'(i + 1)) begin
        errors++; $display("FAIL sat_big_%0d got %0d want %0d", i, eq_cnt, i + 1);
      end
    end
    checks++;
    if ({s_gt_cnt, s_lt_cnt} !== 4'h0) begin
      errors++; $display("FAIL sat_others got %h want 0", {s_gt_cnt, s_lt_cnt});
    end
  endtask

  task automatic test_clear_priority();
    en = 1'b0; clr = 1'b1;
    edge_step();
    clr = 1'b0; en = 1'b1; a = 1'b0; b = 1'b0;
    edge_step();
    edge_step();
    checks++;
    if (eq_cnt !== 8'd2) begin
      errors++; $display("FAIL clr_setup got %0d want 2", eq_cnt);
    end
    clr = 1'b1; a = 1'b0; b = 1'b1;
    edge_step();
    checks++;
    if ({gt_cnt, eq_cnt, lt_cnt} !== 24'h0) begin
      errors++; $display("FAIL clr_cnt got %h want 000000", {gt_cnt, eq_cnt, lt_cnt});
    end
    checks++;
    if ({gt, eq, lt, vld} !== 4'b0011) begin
      errors++; $display("FAIL clr_flags got %b want 0011", {gt, eq, lt, vld});
    end
    clr = 1'b0;
    edge_step();
    checks++;
    if (lt_cnt !== 8'd1) begin
      errors++; $display("FAIL clr_next got %0d want 1", lt_cnt);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b0; clr = 1'b1;
    edge_step();
    clr = 1'b0; en = 1'b1; a = 1'b1; b = 1'b0;
    for (int i = 0; i < 5; i++) edge_step();
    checks++;
    if ({gt, gt_cnt} !== {1'b1, 8'd5}) begin
      errors++; $display("FAIL arst_setup got %b/%0d want 1/5", gt, gt_cnt);
    end
    en = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({gt, eq, lt, vld, gt_cnt, eq_cnt, lt_cnt} !== 28'h0) begin
      errors++; $display("FAIL arst_clear got %h want 0", {gt, eq, lt, vld, gt_cnt, eq_cnt, lt_cnt});
    end
    #1 rst_n = 1'b1;
    en = 1'b1; a = 1'b1; b = 1'b1;
    edge_step();
    checks++;
    if ({gt, eq, lt, vld, eq_cnt, gt_cnt} !== {4'b0101, 8'd1, 8'd0}) begin
      errors++; $display("FAIL arst_first got %b/%0d/%0d want 0101/1/0", {gt, eq, lt, vld}, eq_cnt, gt_cnt);
    end
  endtask

  task automatic test_random();
    int m_cnt [3];
    int m_scnt [3];
    logic [2:0] m_flags;
    logic m_vld;
    int bad = 0;
    en = 1'b0; clr = 1'b1;
    edge_step();
    for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_scnt[k] = 0; end
    m_flags = 3'b010;
    for (int i = 0; i < 1000; i++) begin
      a   = 1'($urandom_range(0, 1));
      b   = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      m_vld = en;
      if (en) m_flags = {a > b, a == b, a < b};
      if (clr) begin
        for (int k = 0; k < 3; k++) begin m_cnt[k] = 0; m_scnt[k] = 0; end
      end else if (en) begin
        for (int k = 0; k < 3; k++) begin
          if (m_flags[2-k]) begin
            if (m_cnt[k] < 255) m_cnt[k]++;
            if (m_scnt[k] < 3) m_scnt[k]++;
          end
        end
      end
      edge_step();
      checks++;
      if ({gt, eq, lt, vld, gt_cnt, eq_cnt, lt_cnt} !==
          {m_flags, m_vld, 8'(m_cnt[0]), 8'(m_cnt[1]), 8'(m_cnt[2])}) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_%0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", i,
                   {gt, eq, lt, vld}, gt_cnt, eq_cnt, lt_cnt,
                   {m_flags, m_vld}, m_cnt[0], m_cnt[1], m_cnt[2]);
      end
      checks++;
      if ({s_gt, s_eq, s_lt, s_vld, s_gt_cnt, s_eq_cnt, s_lt_cnt} !==
          {m_flags, m_vld, 2'(m_scnt[0]), 2'(m_scnt[1]), 2'(m_scnt[2])}) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_small_%0d got %b/%0d/%0d/%0d want %b/%0d/%0d/%0d", i,
                   {s_gt, s_eq, s_lt, s_vld}, s_gt_cnt, s_eq_cnt, s_lt_cnt,
                   {m_flags, m_vld}, m_scnt[0], m_scnt[1], m_scnt[2]);
      end
      checks++;
      if ((32'(gt) + 32'(eq) + 32'(lt)) != 1) begin
        errors++;
        if (bad++ < 10) $display("FAIL rand_onehot_%0d got %b want one-hot", i, {gt, eq, lt});
      end
    end
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_enable_hold();
    test_saturation();
    test_clear_priority();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
